// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, opcode values and the
// fetch-stage state type used by both the decode and fetch stages.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_NOT = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_STD = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_LDM = 6'd11;

  // All-zero word placed in IF/ID while an immediate is being captured.
  localparam int unsigned BUBBLE_INSTR = 0;

  typedef enum logic {
    RUN = 1'b0,
    IMM = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: wrap-around up-counter with synchronous active-low reset
// and a count enable that is dropped while the pipeline is stalled.
module pc_reg #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_en) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC, fills IF/ID and, when decode flags
// a two-word instruction, captures the following word as an immediate.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] imm_out,
  output logic               imm_valid
);

  logic [ADDR_W-1:0]  w_pc;
  logic               w_capture;
  fetch_state_t       r_state;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic               r_if_id_valid;
  logic [INSTR_W-1:0] r_imm_out;
  logic               r_imm_valid;

  // The PC advances on every unstalled cycle, whether it issues or captures.
  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en (~stall),
    .o_pc (w_pc)
  );

  // A bubble can never be two-word, so flushes against one are ignored.
  assign w_capture = (r_state == RUN) && flush_req && r_if_id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
      r_imm_out     <= '0;
      r_imm_valid   <= 1'b0;
    end else if (!stall) begin
      if (w_capture) begin
        r_imm_out     <= imem_rdata;
        r_imm_valid   <= 1'b1;
        r_if_id_instr <= INSTR_W'(BUBBLE_INSTR);
        r_if_id_valid <= 1'b0;
        r_state       <= IMM;
      end else begin
        r_if_id_instr <= imem_rdata;
        r_if_id_valid <= 1'b1;
        r_imm_valid   <= 1'b0;
        r_state       <= RUN;
      end
    end
  end

  assign imem_addr   = w_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign imm_out     = r_imm_out;
  assign imm_valid   = r_imm_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and
// hand-computed spot checks; uses a 4-bit PC so the wrap is reachable.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush_req = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] if_id_instr;
  logic          if_id_valid;
  logic [IW-1:0] imm_out;
  logic          imm_valid;

  logic [IW-1:0] mem [16];
  int checks = 0;
  int failures = 0;

  // Reference model state: what the outputs must be after each edge.
  int            m_pc = 0;
  logic [IW-1:0] m_instr = '0;
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_imm = '0;
  logic          m_immv = 1'b0;
  bit            m_pending = 1'b0;
  bit            m_ready = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_unit #(
    .ADDR_W (AW),
    .INSTR_W(IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush_req  (flush_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .imm_out    (imm_out),
    .imm_valid  (imm_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a two-word instruction consumes exactly one fetch slot as an immediate.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_instr = '0; m_valid = 1'b0; m_imm = '0; m_immv = 1'b0;
      m_pending = 1'b0; m_ready = 1'b1;
    end else if (!stall) begin
      if (!m_pending && flush_req && m_valid) begin
        m_imm = mem[m_pc]; m_immv = 1'b1; m_instr = '0; m_valid = 1'b0;
        m_pending = 1'b1;
      end else begin
        m_instr = mem[m_pc]; m_valid = 1'b1; m_immv = 1'b0; m_pending = 1'b0;
      end
      m_pc = (m_pc + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model_imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("model_if_id_instr", 32'(if_id_instr), 32'(m_instr));
      chk("model_if_id_valid", 32'(if_id_valid), 32'(m_valid));
      chk("model_imm_out", 32'(imm_out), 32'(m_imm));
      chk("model_imm_valid", 32'(imm_valid), 32'(m_immv));
    end
  end

  task automatic cyc(input logic s, input logic f);
    stall = s;
    flush_req = f;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%b stall=%b flush=%b addr=%0d instr=%h v=%b imm=%h iv=%b",
             $time, rst_n, s, f, imem_addr, if_id_instr, if_id_valid, imm_out, imm_valid);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset release and straight-line fetch.
    fill_mem();
    mem[0] = 16'h0401; mem[1] = 16'h1000; mem[2] = 16'h2C00; mem[3] = 16'h0800;
    do_reset();
    chk("reset_addr", 32'(imem_addr), 32'd0);
    chk("reset_valid", 32'(if_id_valid), 32'd0);
    chk("reset_imm", 32'(imm_out), 32'd0);
    cyc(1'b0, 1'b0); chk("fetch0", 32'(if_id_instr), 32'h0401);
    chk("fetch0_valid", 32'(if_id_valid), 32'd1);
    cyc(1'b0, 1'b0); chk("fetch1", 32'(if_id_instr), 32'h1000);
    cyc(1'b0, 1'b0); chk("fetch2", 32'(if_id_instr), 32'h2C00);
    cyc(1'b0, 1'b0); chk("fetch3", 32'(if_id_instr), 32'h0800);

    // LDM at 2 with immediate 0xBEEF at 3; flush against post-reset bubble ignored.
    fill_mem();
    mem[0] = 16'h0401; mem[1] = 16'h1000; mem[2] = 16'h2C00; mem[3] = 16'hBEEF;
    mem[4] = 16'h0800; mem[5] = 16'h2C00; mem[6] = 16'h1234; mem[7] = 16'h0401;
    do_reset();
    cyc(1'b0, 1'b1); chk("bubble_flush_ignored", 32'(if_id_instr), 32'h0401);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0); chk("ldm_in_ifid_addr", 32'(imem_addr), 32'd3);
    cyc(1'b0, 1'b1);
    chk("cap_valid", 32'(if_id_valid), 32'd0);
    chk("cap_immv", 32'(imm_valid), 32'd1);
    chk("cap_imm", 32'(imm_out), 32'hBEEF);
    chk("cap_addr", 32'(imem_addr), 32'd4);
    cyc(1'b0, 1'b0);
    chk("after_cap_instr", 32'(if_id_instr), 32'h0800);
    chk("after_cap_immv", 32'(imm_valid), 32'd0);
    chk("after_cap_imm", 32'(imm_out), 32'hBEEF);

    // Stall together with flush: everything frozen, capture after stall drops.
    cyc(1'b0, 1'b0); chk("ldm2_instr", 32'(if_id_instr), 32'h2C00);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1);
      chk("stall_addr", 32'(imem_addr), 32'd6);
      chk("stall_instr", 32'(if_id_instr), 32'h2C00);
      chk("stall_immv", 32'(imm_valid), 32'd0);
    end
    cyc(1'b0, 1'b1);
    chk("post_stall_imm", 32'(imm_out), 32'h1234);
    chk("post_stall_immv", 32'(imm_valid), 32'd1);
    cyc(1'b1, 1'b1); chk("stall_holds_immv", 32'(imm_valid), 32'd1);
    // Flush held through the IMM cycle yields a single bubble.
    cyc(1'b0, 1'b1);
    chk("imm_flush_ignored_valid", 32'(if_id_valid), 32'd1);
    chk("imm_flush_ignored_instr", 32'(if_id_instr), 32'h0401);
    chk("imm_flush_ignored_immv", 32'(imm_valid), 32'd0);
    cyc(1'b0, 1'b0);

    // PC wrap: LDM at 15 takes its immediate from address 0.
    fill_mem();
    mem[0] = 16'hCAFE; mem[15] = 16'h2C00;
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_instr", 32'(if_id_instr), 32'h2C00);
    cyc(1'b0, 1'b1);
    chk("wrap_imm", 32'(imm_out), 32'hCAFE);
    chk("wrap_next_addr", 32'(imem_addr), 32'd1);

    // Reset taken in the IMM cycle.
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    chk("rst_imm_addr", 32'(imem_addr), 32'd0);
    chk("rst_imm_imm", 32'(imm_out), 32'd0);
    chk("rst_imm_immv", 32'(imm_valid), 32'd0);
    chk("rst_imm_valid", 32'(if_id_valid), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    chk("restart_instr", 32'(if_id_instr), 32'hCAFE);
    chk("restart_valid", 32'(if_id_valid), 32'd1);
    cyc(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
